// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit add/subtract around one full_adder cell and a registered carry.
// Latency: WIDTH+1 cycles from the accepting start edge to the end of the done pulse. All outputs are registered.
// Backpressure: none. i_start is accepted only in IDLE; starts in RUN or DONE are dropped, not queued.

// Single-bit full adder cell. Each clock, serial_adder feeds it one operand bit pair and the carry.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
endmodule

module serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_sub,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_zero
);
    // The counter stops at WIDTH after the last bit, so it needs one value beyond WIDTH-1.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_sum;
    logic             fa_cout;

    // The one adder cell always sees the current LSBs and the carry from the previous bit.
    full_adder u_fa (
        .i_a    (a_q[0]),
        .i_b    (b_q[0]),
        .i_cin  (carry_q),
        .o_sum  (fa_sum),
        .o_cout (fa_cout)
    );

    // Next-state logic: operand loading, bit sequencing, and result capture on the last bit.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    // Subtraction is A + ~B + 1. The +1 is injected as the initial carry.
                    state_d = RUN;
                    a_d     = i_a;
                    b_d     = i_sub ? ~i_b : i_b;
                    carry_d = i_sub;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d              = a_q >> 1;
                b_d              = b_q >> 1;
                res_d            = res_q >> 1;
                res_d[WIDTH-1]   = fa_sum;
                carry_d          = fa_cout;
                cnt_d            = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // On the MSB, carry_q is the carry into the sign bit.
                    // Overflow occurs when that carry differs from the carry out.
                    state_d  = DONE;
                    result_d = res_d;
                    cout_d   = fa_cout;
                    ovf_d    = carry_q ^ fa_cout;
                    zero_d   = (res_d == '0);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are registered from the next state, so they match state_q after the edge.
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and datapath registers. Reset clears everything, which aborts any operation in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_result   = result_q;
    assign o_carry    = cout_q;
    assign o_overflow = ovf_q;
    assign o_zero     = zero_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed-vector bench for serial_adder at WIDTH=32 and WIDTH=8.
// Latency: checks the exact edge timing of busy and done against the start edge.
// Backpressure: none. Inputs are driven just after posedge, and outputs are sampled 1ns after posedge.
module tb_serial_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] ia = '0;
    logic [31:0] ib = '0;
    logic        busy, done, carry, ovf, zero;
    logic [31:0] result;

    logic        start8 = 1'b0;
    logic        sub8 = 1'b0;
    logic [7:0]  ia8 = '0;
    logic [7:0]  ib8 = '0;
    logic        busy8, done8, carry8, ovf8, zero8;
    logic [7:0]  result8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_sub(sub),
        .i_a(ia), .i_b(ib), .o_busy(busy), .o_done(done), .o_result(result),
        .o_carry(carry), .o_overflow(ovf), .o_zero(zero)
    );

    serial_adder #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_sub(sub8),
        .i_a(ia8), .i_b(ib8), .o_busy(busy8), .o_done(done8), .o_result(result8),
        .o_carry(carry8), .o_overflow(ovf8), .o_zero(zero8)
    );

    // Single comparison point: count it, and report any mismatch.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Issue one 32-bit operation and check its timing and results.
    // If pulse_at is nonzero, a spurious start with other operands is sampled at that edge.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] er, input logic ec,
                          input logic eo, input logic ez, input int pulse_at);
        int bad;
        logic [31:0] prev;
        prev = result;
        start = 1'b1; ia = a; ib = b; sub = s;
        @(posedge clk); #1;                              // E0
        start = 1'b0; ia = $urandom; ib = $urandom; sub = 1'($urandom_range(0, 1));
        chk({tag, ".busy_e0"}, 32'(busy), 32'd1);
        chk({tag, ".hold_e0"}, result, prev);
        bad = 0;
        for (int k = 1; k < 32; k++) begin
            if (pulse_at != 0 && k == pulse_at) begin
                start = 1'b1; ia = 32'h1234_5678; ib = 32'h0BAD_F00D; sub = ~s;
            end
            @(posedge clk); #1;                          // Ek
            start = 1'b0;
            if (busy !== 1'b1 || done !== 1'b0 || result !== prev) bad++;
        end
        chk({tag, ".run_window"}, 32'(bad), 32'd0);
        @(posedge clk); #1;                              // E32
        chk({tag, ".done_e32"}, 32'(done), 32'd1);
        chk({tag, ".busy_e32"}, 32'(busy), 32'd0);
        chk({tag, ".result"}, result, er);
        chk({tag, ".carry"}, 32'(carry), 32'(ec));
        chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
        chk({tag, ".zero"}, 32'(zero), 32'(ez));
        @(posedge clk); #1;                              // E33
        chk({tag, ".done_e33"}, 32'(done), 32'd0);
        chk({tag, ".hold_e33"}, result, er);
    endtask

    initial begin
        int n;
        int seen;

        // Reset state, asserted from time zero.
        #3;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.result", result, 32'd0);
        chk("rst.flags", {29'd0, carry, ovf, zero}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add5p3",   32'd5,         32'd3, 1'b0, 32'd8,         1'b0, 1'b0, 1'b0, 0);
        run_op("wrap",     32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0,         1'b1, 1'b0, 1'b1, 0);
        run_op("sovf_add", 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 0);
        run_op("sub3m5",   32'd3,         32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 0);
        run_op("sub5m5",   32'd5,         32'd5, 1'b1, 32'd0,         1'b1, 1'b0, 1'b1, 0);
        run_op("sovf_sub", 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 0);
        run_op("ign_start", 32'd100,      32'd23, 1'b0, 32'd123,      1'b0, 1'b0, 1'b0, 10);

        // Reset mid-RUN just after E15: outputs clear immediately, and no done pulse follows.
        start = 1'b1; ia = 32'd7; ib = 32'd9; sub = 1'b0;
        @(posedge clk); #1;                              // E0
        start = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
        end
        chk("mid.busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid.busy", 32'(busy), 32'd0);
        chk("mid.result", result, 32'd0);
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done !== 1'b0) seen++;
        end
        chk("mid.no_done", 32'(seen), 32'd0);
        run_op("after_rst", 32'd1, 32'd1, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0, 0);

        // WIDTH=8 instance: done must appear exactly 8 edges after E0.
        start8 = 1'b1; ia8 = 8'd5; ib8 = 8'd3; sub8 = 1'b0;
        @(posedge clk); #1;                              // E0
        start8 = 1'b0; ia8 = 8'hA5; ib8 = 8'h5A;
        n = 0;
        while (done8 !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("w8.latency", 32'(n), 32'd8);
        chk("w8.result", 32'(result8), 32'd8);
        chk("w8.flags", {29'd0, carry8, ovf8, zero8}, 32'd0);
        @(posedge clk); #1;
        start8 = 1'b1; ia8 = 8'h7F; ib8 = 8'h01; sub8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        n = 0;
        while (done8 !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("w8.ovf_latency", 32'(n), 32'd8);
        chk("w8.ovf_result", 32'(result8), 32'h80);
        chk("w8.ovf_flags", {29'd0, carry8, ovf8, zero8}, 32'b010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
